// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding and load-use bubble
// insertion; drives the operation/a/b inputs of the downstream alu.
module alu_operand_stage #(
   parameter int N     = 32,
   parameter int REG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [3:0]       id_operation,
   input  logic [REG_W-1:0] id_rs1_addr,
   input  logic [REG_W-1:0] id_rs2_addr,
   input  logic [REG_W-1:0] id_rd_addr,
   input  logic [N-1:0]     id_rs1_data,
   input  logic [N-1:0]     id_rs2_data,
   input  logic [N-1:0]     id_imm,
   input  logic             id_use_imm,
   input  logic             id_reg_write,
   input  logic             id_mem_read,
   input  logic             stall,
   input  logic             flush,
   input  logic             exmem_reg_write,
   input  logic [REG_W-1:0] exmem_rd,
   input  logic [N-1:0]     exmem_result,
   input  logic             memwb_reg_write,
   input  logic [REG_W-1:0] memwb_rd,
   input  logic [N-1:0]     memwb_result,
   output logic [3:0]       alu_operation,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [N-1:0]     ex_store_data,
   output logic             ex_valid,
   output logic [REG_W-1:0] ex_rd_addr,
   output logic             ex_reg_write,
   output logic             ex_mem_read,
   output logic             load_use_stall
);

   typedef struct packed {
      logic             valid;
      logic [3:0]       operation;
      logic [REG_W-1:0] rs1_addr;
      logic [REG_W-1:0] rs2_addr;
      logic [REG_W-1:0] rd_addr;
      logic [N-1:0]     rs1_data;
      logic [N-1:0]     rs2_data;
      logic [N-1:0]     imm;
      logic             use_imm;
      logic             reg_write;
      logic             mem_read;
   } stage_t;

   stage_t ex_q;
   stage_t id_fields;
   logic [N-1:0] fwd_rs1;
   logic [N-1:0] fwd_rs2;

   always_comb begin
      id_fields           = '0;
      id_fields.valid     = 1'b1;
      id_fields.operation = id_operation;
      id_fields.rs1_addr  = id_rs1_addr;
      id_fields.rs2_addr  = id_rs2_addr;
      id_fields.rd_addr   = id_rd_addr;
      id_fields.rs1_data  = id_rs1_data;
      id_fields.rs2_data  = id_rs2_data;
      id_fields.imm       = id_imm;
      id_fields.use_imm   = id_use_imm;
      id_fields.reg_write = id_reg_write;
      id_fields.mem_read  = id_mem_read;
   end

   // The load in EX only has its data after MEM, so a dependent decode must wait one cycle.
   assign load_use_stall = ex_q.valid & ex_q.mem_read & (ex_q.rd_addr != '0) & id_valid &
                           ((ex_q.rd_addr == id_rs1_addr) | (ex_q.rd_addr == id_rs2_addr));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ex_q <= '0;
      else if (flush)
         ex_q <= '0;
      else if (stall)
         ex_q <= ex_q;
      else if (load_use_stall || !id_valid)
         ex_q <= '0;
      else
         ex_q <= id_fields;
   end

   // Youngest producer wins; x0 is hard-wired zero and never forwarded.
   function automatic logic [N-1:0] forward(input logic [REG_W-1:0] rs,
                                            input logic [N-1:0]     reg_data);
      if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs))
         return exmem_result;
      else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs))
         return memwb_result;
      else
         return reg_data;
   endfunction

   assign fwd_rs1       = forward(ex_q.rs1_addr, ex_q.rs1_data);
   assign fwd_rs2       = forward(ex_q.rs2_addr, ex_q.rs2_data);
   assign alu_operation = ex_q.operation;
   assign alu_a         = fwd_rs1;
   assign alu_b         = ex_q.use_imm ? ex_q.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ex_valid      = ex_q.valid;
   assign ex_rd_addr    = ex_q.rd_addr;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: a slot-level model checked every cycle plus
// directed vectors with literal expectations.
module tb_alu_operand_stage;

   localparam int N     = 32;
   localparam int REG_W = 5;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [3:0]       id_operation;
   logic [REG_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [N-1:0]     id_rs1_data, id_rs2_data, id_imm;
   logic             id_use_imm, id_reg_write, id_mem_read;
   logic             stall, flush;
   logic             exmem_reg_write, memwb_reg_write;
   logic [REG_W-1:0] exmem_rd, memwb_rd;
   logic [N-1:0]     exmem_result, memwb_result;
   logic [3:0]       alu_operation;
   logic [N-1:0]     alu_a, alu_b, ex_store_data;
   logic             ex_valid, ex_reg_write, ex_mem_read, load_use_stall;
   logic [REG_W-1:0] ex_rd_addr;

   int total = 0;
   int bad   = 0;

   alu_operand_stage #(.N(N), .REG_W(REG_W)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_operation(id_operation),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .stall(stall), .flush(flush),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
      .alu_operation(alu_operation), .alu_a(alu_a), .alu_b(alu_b),
      .ex_store_data(ex_store_data), .ex_valid(ex_valid), .ex_rd_addr(ex_rd_addr),
      .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
      .load_use_stall(load_use_stall)
   );

   // clock / reset
   always #5 clk = ~clk;

   // model: the instruction occupying the EX slot (all zero = bubble)
   typedef struct {
      bit        valid;
      bit [3:0]  op;
      int        rs1, rs2, rd;
      bit [31:0] d1, d2, imm;
      bit        use_imm, rw, mr;
   } slot_t;

   slot_t m;

   function automatic slot_t empty_slot();
      slot_t s;
      s.valid = 0; s.op = 0; s.rs1 = 0; s.rs2 = 0; s.rd = 0;
      s.d1 = 0; s.d2 = 0; s.imm = 0; s.use_imm = 0; s.rw = 0; s.mr = 0;
      return s;
   endfunction

   function automatic bit model_hazard();
      if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 0;
      return (m.rd == int'(id_rs1_addr)) || (m.rd == int'(id_rs2_addr));
   endfunction

   function automatic bit [31:0] model_operand(int rs, bit [31:0] file_val);
      if (rs == 0) return file_val;
      if (exmem_reg_write && int'(exmem_rd) == rs) return exmem_result;
      if (memwb_reg_write && int'(memwb_rd) == rs) return memwb_result;
      return file_val;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= empty_slot();
      else if (flush) m <= empty_slot();
      else if (stall) m <= m;
      else if (model_hazard() || !id_valid) m <= empty_slot();
      else begin
         slot_t s;
         s.valid = 1; s.op = id_operation;
         s.rs1 = int'(id_rs1_addr); s.rs2 = int'(id_rs2_addr); s.rd = int'(id_rd_addr);
         s.d1 = id_rs1_data; s.d2 = id_rs2_data; s.imm = id_imm;
         s.use_imm = id_use_imm; s.rw = id_reg_write; s.mr = id_mem_read;
         m <= s;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // scoreboard: one compare point per cycle, away from the active edge
   always @(negedge clk) begin
      logic [31:0] exp_q[$];
      logic [31:0] a_exp, s_exp;
      a_exp = model_operand(m.rs1, m.d1);
      s_exp = model_operand(m.rs2, m.d2);
      exp_q.push_back(32'(m.op));
      exp_q.push_back(a_exp);
      exp_q.push_back(m.use_imm ? m.imm : s_exp);
      exp_q.push_back(s_exp);
      exp_q.push_back({m.valid, m.rw, m.mr, 24'd0, 5'(m.rd)});
      exp_q.push_back(32'(model_hazard()));
      chk("cyc_op",    32'(alu_operation), exp_q.pop_front());
      chk("cyc_a",     alu_a,              exp_q.pop_front());
      chk("cyc_b",     alu_b,              exp_q.pop_front());
      chk("cyc_store", ex_store_data,      exp_q.pop_front());
      chk("cyc_ctrl",  {ex_valid, ex_reg_write, ex_mem_read, 24'd0, ex_rd_addr},
          exp_q.pop_front());
      chk("cyc_lus",   32'(load_use_stall), exp_q.pop_front());
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input bit v, input bit [3:0] op, input int a1, input int a2,
                           input int rd, input bit [31:0] d1, input bit [31:0] d2,
                           input bit [31:0] imm, input bit ui, input bit rw, input bit mr);
      id_valid = v; id_operation = op;
      id_rs1_addr = 5'(a1); id_rs2_addr = 5'(a2); id_rd_addr = 5'(rd);
      id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
      id_use_imm = ui; id_reg_write = rw; id_mem_read = mr;
   endtask

   task automatic clear_fwd();
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   initial begin
      logic [31:0] sra_out;
      rst_n = 0; stall = 0; flush = 0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      clear_fwd();
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      chk("reset_valid", 32'(ex_valid), 32'd0);
      chk("reset_a", alu_a, 32'd0);

      // pass-through ADD
      drive_id(1, 4'b0000, 3, 4, 5, 32'd1, 32'd2, 32'd0, 0, 1, 0);
      step();
      chk("add_a", alu_a, 32'd1);
      chk("add_b", alu_b, 32'd2);
      chk("add_valid", 32'(ex_valid), 32'd1);

      // forwarding priority
      drive_id(1, 4'b0000, 5, 6, 10, 32'h11, 32'h66, 32'd0, 0, 1, 0);
      step();
      exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hA;
      memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hB;
      #1 chk("fwd_exmem", alu_a, 32'hA);
      exmem_rd = 0;
      #1 chk("fwd_memwb", alu_a, 32'hB);
      drive_id(1, 4'b0000, 0, 0, 11, 32'h22, 32'h23, 32'd0, 0, 1, 0);
      memwb_rd = 0;
      step();
      chk("fwd_x0_a", alu_a, 32'h22);
      chk("fwd_x0_store", ex_store_data, 32'h23);
      clear_fwd();

      // load-use
      drive_id(1, 4'b0000, 1, 2, 7, 32'h100, 32'd0, 32'd4, 1, 1, 1);
      step();
      drive_id(1, 4'b0000, 1, 7, 8, 32'h5, 32'h6, 32'd0, 0, 1, 0);
      #1 chk("lu_stall", 32'(load_use_stall), 32'd1);
      step();
      chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
      chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
      step();
      chk("lu_capture_rd", 32'(ex_rd_addr), 32'd8);
      chk("lu_capture_b", alu_b, 32'h6);

      // stall and flush
      drive_id(1, 4'b0010, 12, 13, 9, 32'h33, 32'h44, 32'd0, 0, 1, 0);
      step();
      stall = 1;
      drive_id(1, 4'b0011, 14, 15, 20, 32'h99, 32'h98, 32'd0, 0, 1, 0);
      step();
      step();
      chk("stall_a", alu_a, 32'h33);
      chk("stall_rd", 32'(ex_rd_addr), 32'd9);
      flush = 1;
      step();
      chk("flush_valid", 32'(ex_valid), 32'd0);
      stall = 0; flush = 0;

      // immediate SRA
      drive_id(1, 4'b0111, 16, 17, 21, 32'h8000_0000, 32'h55, 32'd1, 1, 1, 0);
      step();
      chk("imm_a", alu_a, 32'h8000_0000);
      chk("imm_b", alu_b, 32'd1);
      chk("imm_store", ex_store_data, 32'h55);
      sra_out = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      chk("imm_sra", sra_out, 32'hC000_0000);

      // undefined opcode reaches alu unchanged
      drive_id(1, 4'b1111, 2, 3, 4, 32'h7, 32'h8, 32'd0, 0, 0, 0);
      step();
      chk("op_1111", 32'(alu_operation), 32'hF);

      // mixed traffic, scoreboard only
      for (int i = 0; i < 60; i++) begin
         drive_id(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         exmem_reg_write = 1'($urandom_range(0, 1)); exmem_rd = 5'($urandom_range(0, 7));
         exmem_result = $urandom;
         memwb_reg_write = 1'($urandom_range(0, 1)); memwb_rd = 5'($urandom_range(0, 7));
         memwb_result = $urandom;
         stall = ($urandom_range(0, 5) == 0);
         flush = ($urandom_range(0, 7) == 0);
         step();
      end

      // asynchronous reset mid-cycle while stalling and flushing
      stall = 0; flush = 0; clear_fwd();
      drive_id(1, 4'b0001, 3, 4, 6, 32'h1234, 32'h5678, 32'd0, 0, 1, 1);
      step();
      stall = 1; flush = 1;
      #2 rst_n = 0;
      #1;
      chk("arst_valid", 32'(ex_valid), 32'd0);
      chk("arst_op", 32'(alu_operation), 32'd0);
      chk("arst_a", alu_a, 32'd0);
      chk("arst_b", alu_b, 32'd0);
      step();
      rst_n = 1; stall = 0; flush = 0;
      drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
